bus_control_sequencer: RTL and testbench
========================================

Name: bus_control_sequencer

Overview:
Multi-cycle control unit that drives the single-bus datapath's register-transfer strobes, one step per clock. Runs instruction fetch, decode and execute for ALU register-register ops, MUL/DIV (HI/LO), load and store, and HALT. Every memory access uses a ready handshake with a watchdog counter. Sits beside the datapath: it consumes the IR contents and the memory ready signal, and produces all in/out enables.

Parameters:
WAIT_LIMIT, 15, maximum cycles to wait for mem_ready before entering FAULT (1..255)
OPW, 5, opcode field width (IR[31:27])

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
ir  in  32  IR register contents; opcode=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
mem_ready  in  1  memory completed current Read/Write
PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write  out  1 each  datapath strobes
Rin  out  16  one-hot general-register load enables
Rout  out  16  one-hot general-register bus-drive enables
alu_op  out  5  ALU operation; equals opcode during the Zin execute step, else 0
step  out  4  current step number (debug)
run  out  1  1 while sequencing, 0 in HALT/FAULT

Behaviour:
- State/step register is the only sequential state besides wait_cnt (8 bits). Every output is registered-free Moore decode of state plus the latched ir fields. At most one Rout bit and one bus driver are active per cycle.
- clr low (async): state=T0, wait_cnt=0, run=1 after release. All strobes are 0 while clr is low. A mid-instruction reset abandons the instruction with no partial register write.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 until mem_ready; Read and MDRin stay asserted.
  - T2: MDRout, IRin.
  - T3: decode.
- ALU ops add=00011, sub=00100, and=00101, or=00110:
  - T3: Rout[rb], Yin.
  - T4: Rout[rc], alu_op=opcode, Zin.
  - T5: Zlowout, Rin[ra].
  - Next T0.
- mul=01111, div=10000:
  - T3 and T4 as for ALU ops.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Next T0.
- ld=00000:
  - T3: Rout[rb], Yin.
  - T4: Cout, alu_op=00011, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait for mem_ready.
  - T7: MDRout, Rin[ra].
- st=00010:
  - T3, T4, T5 as for ld.
  - T6: Rout[ra], MDRin.
  - T7: Write; wait for mem_ready.
- nop=11010 and any undefined opcode: T3 returns directly to T0.
- halt=11011: enter HALT; run=0; all strobes 0; HALT is left only via clr.
- Memory wait:
  - wait_cnt clears on entering a wait step and increments each cycle mem_ready is 0.
  - mem_ready=1 advances on the next edge.
  - If wait_cnt reaches WAIT_LIMIT while mem_ready=0: enter FAULT (run=0, strobes 0, step=4'hF), held until clr.
  - mem_ready already high on the first cycle of a wait step gives zero wait cycles.
- ra=rb (or any field overlap) needs no special handling: reads happen in earlier steps than writes.
- Latency with zero memory wait, counted T0 to the next T0: ALU op 6 cycles, mul/div 7, ld/st 8, nop 4.

Test Plan:
- Reset then fetch: release clr with mem_ready=1 and ir=add(ra=1,rb=2,rc=3). Required: T0 strobes PCout/MARin/IncPC/Zin → T1 PCin/Read/MDRin → T2 IRin → T3 Rout=0x0004, Yin → T4 Rout=0x0008, alu_op=00011 → T5 Rin=0x0002; back at T0 6 cycles after start.
- mul ra=0,rb=4,rc=5. Required: T5 LOin with Zlowout; T6 HIin with Zhighout; Rin stays 0 throughout.
- ld ra=7,rb=2 with mem_ready delayed 3 cycles in T6. Required: step holds at 6 for 3 extra cycles; T7 Rin=0x0080 with MDRout; total 11 cycles.
- st with mem_ready never asserted in T7 and WAIT_LIMIT=15. Required: FAULT after 15 wait cycles; run=0, step=F, all strobes 0; clr pulse returns to T0.
- halt after one add. Required: run drops in the cycle after T3; outputs stay 0 for 50 cycles; clr low resumes at T0.
- Async reset asserted mid-T4 of sub. Required: all strobes go to 0 immediately, without waiting for a clock edge; no Rin pulse; after release, T0 on the first edge.

Source files
------------

// File: rtl/bus_control_sequencer_if.sv
// rtl/bus_control_sequencer_if.sv - IR/memory-ready inputs and datapath strobes between the sequencer and the datapath
interface bus_control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
    logic        Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
    logic [3:0]  step;
    logic        run;

    modport master (
        input  ir, mem_ready,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write,
               Rin, Rout, alu_op, step, run
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zin, Zlowout, Zhighout, HIin, LOin, Cout, Read, Write,
               Rin, Rout, alu_op, step, run
    );
endinterface

// File: rtl/bus_control_sequencer.sv
// rtl/bus_control_sequencer.sv - multi-cycle fetch/decode/execute sequencer for the single-bus datapath
module bus_control_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int OPW        = 5
) (
    input  logic                   clk,
    input  logic                   clr,
    bus_control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        HALT = 4'hE, FAULT = 4'hF
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t         state;
    logic [7:0]     wait_cnt;
    logic [OPW-1:0] opcode;
    logic [3:0]     ra, rb, rc;
    logic           is_alu, is_md, is_ld, is_st, is_halt;
    logic           unused_ir;

    assign opcode    = bus.ir[31 -: OPW];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_md   = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_halt = (opcode == OP_HALT);

    // Wait steps (T1, ld T6, st T7) count misses; every other step keeps wait_cnt cleared
    // so it is zero on entry to the next wait step.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= T0;
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= 8'd0;
            case (state)
                T0: state <= T1;
                T1: begin
                    if (bus.mem_ready) begin
                        state <= T2;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == 8'(WAIT_LIMIT - 1)) state <= FAULT;
                    end
                end
                T2: state <= T3;
                T3: begin
                    if (is_alu || is_md || is_ld || is_st) state <= T4;
                    else if (is_halt)                      state <= HALT;
                    else                                   state <= T0;
                end
                T4: state <= T5;
                T5: state <= is_alu ? T0 : T6;
                T6: begin
                    if (is_md) begin
                        state <= T0;
                    end else if (is_ld) begin
                        if (bus.mem_ready) begin
                            state <= T7;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                            if (wait_cnt == 8'(WAIT_LIMIT - 1)) state <= FAULT;
                        end
                    end else begin
                        state <= T7;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        state <= T0;
                    end else if (bus.mem_ready) begin
                        state <= T0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == 8'(WAIT_LIMIT - 1)) state <= FAULT;
                    end
                end
                HALT:    state <= HALT;
                FAULT:   state <= FAULT;
                default: state <= FAULT;
            endcase
        end
    end

    always_comb begin
        {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin} = 8'd0;
        {bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.Cout, bus.Read, bus.Write} = 8'd0;
        bus.Rin    = 16'd0;
        bus.Rout   = 16'd0;
        bus.alu_op = 5'd0;
        bus.step   = state;
        bus.run    = (state != HALT) && (state != FAULT);
        case (state)
            T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
            T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            T3: if (is_alu || is_md || is_ld || is_st) begin
                bus.Rout = 16'd1 << rb;
                bus.Yin  = 1'b1;
            end
            T4: begin
                bus.Zin = 1'b1;
                if (is_ld || is_st) begin
                    bus.Cout   = 1'b1;
                    bus.alu_op = 5'(OP_ADD);
                end else begin
                    bus.Rout   = 16'd1 << rc;
                    bus.alu_op = 5'(opcode);
                end
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (is_alu)     bus.Rin   = 16'd1 << ra;
                else if (is_md) bus.LOin  = 1'b1;
                else            bus.MARin = 1'b1;
            end
            T6: begin
                if (is_md) begin
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
                end else if (is_ld) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else begin
                    bus.Rout  = 16'd1 << ra;
                    bus.MDRin = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.Rin    = 16'd1 << ra;
                end else begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
        // Reset must silence the datapath immediately, not at the next edge.
        if (!clr) begin
            {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin} = 8'd0;
            {bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.Cout, bus.Read, bus.Write} = 8'd0;
            bus.Rin    = 16'd0;
            bus.Rout   = 16'd0;
            bus.alu_op = 5'd0;
        end
    end
endmodule

// File: tb/tb_bus_control_sequencer.sv
// tb/tb_bus_control_sequencer.sv - scoreboard bench for bus_control_sequencer
module tb_bus_control_sequencer;
    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_pass   = 0;

    bus_control_sequencer_if bus();

    bus_control_sequencer #(.WAIT_LIMIT(15), .OPW(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] S_PCOUT = 16'h8000, S_PCIN = 16'h4000, S_INCPC = 16'h2000, S_MARIN = 16'h1000;
    localparam logic [15:0] S_MDRIN = 16'h0800, S_MDROUT = 16'h0400, S_IRIN = 16'h0200, S_YIN = 16'h0100;
    localparam logic [15:0] S_ZIN = 16'h0080, S_ZLO = 16'h0040, S_ZHI = 16'h0020, S_HIIN = 16'h0010;
    localparam logic [15:0] S_LOIN = 16'h0008, S_COUT = 16'h0004, S_READ = 16'h0002, S_WRITE = 16'h0001;

    localparam logic [63:0] M_FULL   = 64'h03FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M_STROBE = 64'h03FF_FFFF_FFFF_FFE0;
    localparam logic [63:0] M_NOSTEP = 64'h03FF_FFFF_FFFF_FFE1;
    localparam logic [63:0] M_STEPRN = 64'h0000_0000_0000_001F;

    typedef struct {
        string       tag;
        logic        mr;
        logic [63:0] exp;
        logic [63:0] mask;
    } item_t;
    item_t sbq[$];

    function automatic logic [63:0] observed();
        return {6'd0,
                bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
                bus.Zin, bus.Zlowout, bus.Zhighout, bus.HIin, bus.LOin, bus.Cout, bus.Read, bus.Write,
                bus.Rin, bus.Rout, bus.alu_op, bus.step, bus.run};
    endfunction

    function automatic logic [63:0] ev(logic [15:0] s, logic [15:0] rin, logic [15:0] rout,
                                       logic [4:0] aop, logic [3:0] stp, logic rn);
        return {6'd0, s, rin, rout, aop, stp, rn};
    endfunction

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s got=%h want=%h", tag, got, want);
        else              n_pass++;
    endtask

    task automatic push(string tag, logic mr, logic [63:0] exp, logic [63:0] mask);
        item_t it;
        it.tag  = tag;
        it.mr   = mr;
        it.exp  = exp;
        it.mask = mask;
        sbq.push_back(it);
    endtask

    task automatic push_fetch(string tag, int waits);
        push({tag, "_t0"}, 1'b1, ev(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 4'd0, 1'b1), M_FULL);
        for (int i = 0; i < waits; i++)
            push({tag, "_t1w"}, 1'b0, ev(S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 4'd1, 1'b1), M_FULL);
        push({tag, "_t1"}, 1'b1, ev(S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 4'd1, 1'b1), M_FULL);
        push({tag, "_t2"}, 1'b1, ev(S_MDROUT | S_IRIN, 0, 0, 0, 4'd2, 1'b1), M_FULL);
    endtask

    // Each entry: drive mem_ready for the cycle, compare mid-cycle, step past the edge.
    task automatic drain();
        item_t it;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
            bus.mem_ready = it.mr;
            @(negedge clk);
            check_eq(it.tag, observed() & it.mask, it.exp & it.mask);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_pulse(string tag);
        clr = 1'b0;
        #2;
        check_eq({tag, "_low"}, observed() & M_STROBE, 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check_eq({tag, "_rel"}, observed() & M_STEPRN, ev(0, 0, 0, 0, 4'd0, 1'b1));
    endtask

    initial begin
        clr           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir        = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobes", observed() & M_STROBE, 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check_eq("rst_state", observed() & M_STEPRN, ev(0, 0, 0, 0, 4'd0, 1'b1));

        // add r1 = r2 + r3
        push_fetch("add", 0);
        push("add_t3", 1'b1, ev(S_YIN, 0, 16'h0004, 0, 4'd3, 1'b1), M_FULL);
        push("add_t4", 1'b1, ev(S_ZIN, 0, 16'h0008, 5'b00011, 4'd4, 1'b1), M_FULL);
        push("add_t5", 1'b1, ev(S_ZLO, 16'h0002, 0, 0, 4'd5, 1'b1), M_FULL);
        drain();

        // mul r4*r5 into HI/LO, with a slow fetch
        bus.ir = mk_ir(5'b01111, 4'd0, 4'd4, 4'd5);
        push_fetch("mul", 2);
        push("mul_t3", 1'b1, ev(S_YIN, 0, 16'h0010, 0, 4'd3, 1'b1), M_FULL);
        push("mul_t4", 1'b1, ev(S_ZIN, 0, 16'h0020, 5'b01111, 4'd4, 1'b1), M_FULL);
        push("mul_t5", 1'b1, ev(S_ZLO | S_LOIN, 0, 0, 0, 4'd5, 1'b1), M_FULL);
        push("mul_t6", 1'b1, ev(S_ZHI | S_HIIN, 0, 0, 0, 4'd6, 1'b1), M_FULL);
        drain();

        // and r15 = r0 & r15: register-index extremes
        bus.ir = mk_ir(5'b00101, 4'd15, 4'd0, 4'd15);
        push_fetch("and", 0);
        push("and_t3", 1'b1, ev(S_YIN, 0, 16'h0001, 0, 4'd3, 1'b1), M_FULL);
        push("and_t4", 1'b1, ev(S_ZIN, 0, 16'h8000, 5'b00101, 4'd4, 1'b1), M_FULL);
        push("and_t5", 1'b1, ev(S_ZLO, 16'h8000, 0, 0, 4'd5, 1'b1), M_FULL);
        drain();

        // ld r7, with three memory wait cycles in T6
        bus.ir = mk_ir(5'b00000, 4'd7, 4'd2, 4'd0);
        push_fetch("ld", 0);
        push("ld_t3", 1'b1, ev(S_YIN, 0, 16'h0004, 0, 4'd3, 1'b1), M_FULL);
        push("ld_t4", 1'b1, ev(S_COUT | S_ZIN, 0, 0, 5'b00011, 4'd4, 1'b1), M_FULL);
        push("ld_t5", 1'b1, ev(S_ZLO | S_MARIN, 0, 0, 0, 4'd5, 1'b1), M_FULL);
        for (int i = 0; i < 3; i++)
            push("ld_t6w", 1'b0, ev(S_READ | S_MDRIN, 0, 0, 0, 4'd6, 1'b1), M_FULL);
        push("ld_t6", 1'b1, ev(S_READ | S_MDRIN, 0, 0, 0, 4'd6, 1'b1), M_FULL);
        push("ld_t7", 1'b1, ev(S_MDROUT, 16'h0080, 0, 0, 4'd7, 1'b1), M_FULL);
        drain();

        // nop and an undefined opcode both end at T3
        bus.ir = mk_ir(5'b11010, 4'd1, 4'd1, 4'd1);
        push_fetch("nop", 0);
        push("nop_t3", 1'b1, ev(0, 0, 0, 0, 4'd3, 1'b1), M_FULL);
        drain();
        bus.ir = mk_ir(5'b01000, 4'd2, 4'd3, 4'd4);
        push_fetch("undef", 0);
        push("undef_t3", 1'b1, ev(0, 0, 0, 0, 4'd3, 1'b1), M_FULL);
        drain();

        // add then halt; halt holds for 50 cycles
        bus.ir = mk_ir(5'b00011, 4'd4, 4'd5, 4'd6);
        push_fetch("add2", 0);
        push("add2_t3", 1'b1, ev(S_YIN, 0, 16'h0020, 0, 4'd3, 1'b1), M_FULL);
        push("add2_t4", 1'b1, ev(S_ZIN, 0, 16'h0040, 5'b00011, 4'd4, 1'b1), M_FULL);
        push("add2_t5", 1'b1, ev(S_ZLO, 16'h0010, 0, 0, 4'd5, 1'b1), M_FULL);
        drain();
        bus.ir = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
        push_fetch("halt", 0);
        push("halt_t3", 1'b1, ev(0, 0, 0, 0, 4'd3, 1'b1), M_FULL);
        for (int i = 0; i < 50; i++)
            push("halt_hold", 1'b1, ev(0, 0, 0, 0, 4'd0, 1'b0), M_NOSTEP);
        drain();
        clr_pulse("halt_clr");

        // st r3 with memory never ready: FAULT after 15 wait cycles
        bus.ir = mk_ir(5'b00010, 4'd3, 4'd1, 4'd0);
        push_fetch("st", 0);
        push("st_t3", 1'b1, ev(S_YIN, 0, 16'h0002, 0, 4'd3, 1'b1), M_FULL);
        push("st_t4", 1'b1, ev(S_COUT | S_ZIN, 0, 0, 5'b00011, 4'd4, 1'b1), M_FULL);
        push("st_t5", 1'b1, ev(S_ZLO | S_MARIN, 0, 0, 0, 4'd5, 1'b1), M_FULL);
        push("st_t6", 1'b0, ev(S_MDRIN, 0, 16'h0008, 0, 4'd6, 1'b1), M_FULL);
        for (int i = 0; i < 15; i++)
            push("st_t7w", 1'b0, ev(S_WRITE, 0, 0, 0, 4'd7, 1'b1), M_FULL);
        for (int i = 0; i < 5; i++)
            push("fault", 1'b0, ev(0, 0, 0, 0, 4'hF, 1'b0), M_FULL);
        drain();
        clr_pulse("fault_clr");

        // sub interrupted by async reset in T4
        bus.ir = mk_ir(5'b00100, 4'd1, 4'd2, 4'd3);
        push_fetch("sub", 0);
        push("sub_t3", 1'b1, ev(S_YIN, 0, 16'h0004, 0, 4'd3, 1'b1), M_FULL);
        drain();
        @(negedge clk);
        check_eq("sub_t4", observed(), ev(S_ZIN, 0, 16'h0008, 5'b00100, 4'd4, 1'b1));
        #2;
        clr = 1'b0;
        #1;
        check_eq("async_rst", observed() & M_STROBE, 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_no_rin", observed() & M_STROBE, 64'd0);
        clr = 1'b1;
        push("rel_t0", 1'b1, ev(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 4'd0, 1'b1), M_FULL);
        push("rel_t1", 1'b1, ev(S_ZLO | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 4'd1, 1'b1), M_FULL);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
